// File: rtl/apb_mem_bridge_pkg.sv
// Shared encodings for the APB-to-memory-port bridge: FSM states, APB
// response codes and the address-window helper used by the top level.
package apb_mem_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_RESP  = 2'd2;

    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

    // Inclusive unsigned window test. Operands are widened to 64 bits so a
    // window starting at zero compares against a variable, not a constant.
    // lo > hi can never match, so such a window rejects every access.
    function automatic logic addr_in_window(input logic [63:0] addr,
                                            input logic [63:0] lo,
                                            input logic [63:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/apb_mem_bridge_if.sv
// Bus bundle for the bridge: APB4 slave side plus the valid/ready memory
// port. slave = bridge view, master = APB master + memory target view.
interface apb_mem_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] io_apbOut_PADDR;
    logic              io_apbOut_PSEL;
    logic              io_apbOut_PENABLE;
    logic              io_apbOut_PWRITE;
    logic [DATA_W-1:0] io_apbOut_PWDATA;
    logic [STRB_W-1:0] io_apbOut_PSTRB;
    logic              io_apbOut_PREADY;
    logic [DATA_W-1:0] io_apbOut_PRDATA;
    logic              io_apbOut_PSLVERROR;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  io_apbOut_PADDR, io_apbOut_PSEL, io_apbOut_PENABLE,
               io_apbOut_PWRITE, io_apbOut_PWDATA, io_apbOut_PSTRB,
               mem_ready, mem_rdata,
        output io_apbOut_PREADY, io_apbOut_PRDATA, io_apbOut_PSLVERROR,
               mem_valid, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output io_apbOut_PADDR, io_apbOut_PSEL, io_apbOut_PENABLE,
               io_apbOut_PWRITE, io_apbOut_PWDATA, io_apbOut_PSTRB,
               mem_ready, mem_rdata,
        input  io_apbOut_PREADY, io_apbOut_PRDATA, io_apbOut_PSLVERROR,
               mem_valid, mem_addr, mem_wdata, mem_wstrb
    );

endinterface

// File: rtl/apb_mem_bridge_timeout_cnt.sv
// Ready-wait watchdog. Counts cycles while run is high; expired flags the
// cycle in which the count has reached TIMEOUT-1 and the target is still
// not ready. TIMEOUT=0 removes the watchdog entirely.
module bridge_timeout_cnt #(
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired
);

    if (TIMEOUT == 0) begin : g_off
        logic unused_in;
        assign unused_in = ^{clk, reset, run, clear};
        assign expired   = 1'b0;
    end else begin : g_on
        logic [TO_W-1:0] cnt;

        // Wait counter: cleared outside the issue phase, advances per stalled cycle
        always_ff @(posedge clk) begin
            if (reset || clear) begin
                cnt <= '0;
            end else if (run) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign expired = run && (cnt == TO_W'(TIMEOUT - 1));
    end

endmodule

// File: rtl/apb_mem_bridge.sv
// APB4 slave to valid/ready memory-port bridge. One outstanding transfer:
// the setup phase is latched in IDLE, the request is held in ISSUE until the
// target responds or the watchdog fires, and RESP returns a registered
// PREADY/PSLVERR/PRDATA for a single cycle.
module apb_mem_bridge
    import apb_mem_pkg::*;
#(
    parameter int              ADDR_W      = 32,
    parameter int              DATA_W      = 32,
    parameter logic [ADDR_W-1:0] ADDR_LO   = '0,
    parameter logic [ADDR_W-1:0] ADDR_HI   = '1,
    parameter bit              ALIGN_CHECK = 1'b1,
    parameter bit              USE_PSTRB   = 1'b1,
    parameter int              TO_W        = 16,
    parameter int              TIMEOUT     = 256
) (
    input  logic             clk,
    input  logic             reset,
    apb_mem_bridge_if.slave  bus
);

    localparam int STRB_W = DATA_W / 8;
    localparam int AL_W   = $clog2(STRB_W);

    state_t            state;
    logic              mem_valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              wr_q;
    logic              pready_q;
    logic              pslverr_q;
    logic [DATA_W-1:0] prdata_q;

    logic              setup;
    logic              misaligned;
    logic              addr_ok;
    logic [STRB_W-1:0] setup_strb;
    logic              to_run;
    logic              to_clear;
    logic              to_expired;

    // A setup phase is PSEL without PENABLE; an access phase alone is ignored
    assign setup = bus.io_apbOut_PSEL && !bus.io_apbOut_PENABLE;

    if (ALIGN_CHECK && (AL_W > 0)) begin : g_align
        assign misaligned = |bus.io_apbOut_PADDR[AL_W-1:0];
    end else begin : g_noalign
        assign misaligned = 1'b0;
    end

    assign addr_ok = addr_in_window(64'(bus.io_apbOut_PADDR), 64'(ADDR_LO), 64'(ADDR_HI))
                     && !misaligned;

    // Byte enables for the request; zero strobes mark a read on the mem side
    always_comb begin
        setup_strb = '0;
        if (bus.io_apbOut_PWRITE) begin
            setup_strb = USE_PSTRB ? bus.io_apbOut_PSTRB : '1;
        end
    end

    assign to_run   = (state == ST_ISSUE) && !bus.mem_ready;
    assign to_clear = (state != ST_ISSUE);

    bridge_timeout_cnt #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .run     (to_run),
        .clear   (to_clear),
        .expired (to_expired)
    );

    // Transfer FSM with request registers and registered APB response
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            mem_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wr_q        <= 1'b0;
            pready_q    <= 1'b0;
            pslverr_q   <= RESP_OKAY;
            prdata_q    <= '0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= RESP_OKAY;
            case (state)
                ST_IDLE: begin
                    if (setup) begin
                        addr_q  <= bus.io_apbOut_PADDR;
                        wdata_q <= bus.io_apbOut_PWDATA;
                        wstrb_q <= setup_strb;
                        wr_q    <= bus.io_apbOut_PWRITE;
                        if (addr_ok) begin
                            mem_valid_q <= 1'b1;
                            state       <= ST_ISSUE;
                        end else begin
                            // Rejected locally: answer with zero wait states
                            pready_q  <= 1'b1;
                            pslverr_q <= RESP_SLVERR;
                            prdata_q  <= '0;
                            state     <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    // Ready is tested first so it wins over a same-cycle timeout
                    if (bus.mem_ready) begin
                        mem_valid_q <= 1'b0;
                        pready_q    <= 1'b1;
                        pslverr_q   <= RESP_OKAY;
                        prdata_q    <= wr_q ? '0 : bus.mem_rdata;
                        state       <= ST_RESP;
                    end else if (to_expired) begin
                        mem_valid_q <= 1'b0;
                        pready_q    <= 1'b1;
                        pslverr_q   <= RESP_SLVERR;
                        prdata_q    <= '0;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    mem_valid_q <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_valid           = mem_valid_q;
    assign bus.mem_addr            = addr_q;
    assign bus.mem_wdata           = wdata_q;
    assign bus.mem_wstrb           = wstrb_q;
    assign bus.io_apbOut_PREADY    = pready_q;
    assign bus.io_apbOut_PSLVERROR = pslverr_q;
    assign bus.io_apbOut_PRDATA    = prdata_q;

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Directed bench for apb_mem_bridge. Two instances: dut_a has an open window
// and byte strobes; dut_b has window 0x1000..0x1FFF and forces full strobes.
// Inputs change 1 time unit after posedge, outputs are sampled at negedge.
module tb_apb_mem_bridge;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    int   last_pr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_mem_bridge_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
    apb_mem_bridge_if #(.ADDR_W(32), .DATA_W(32)) ifb ();

    apb_mem_bridge #(
        .ADDR_W(32), .DATA_W(32), .ADDR_LO(32'h0), .ADDR_HI(32'hFFFF_FFFF),
        .ALIGN_CHECK(1'b1), .USE_PSTRB(1'b1), .TO_W(16), .TIMEOUT(8)
    ) dut_a (.clk(clk), .reset(reset), .bus(ifa));

    apb_mem_bridge #(
        .ADDR_W(32), .DATA_W(32), .ADDR_LO(32'h1000), .ADDR_HI(32'h1FFF),
        .ALIGN_CHECK(1'b1), .USE_PSTRB(1'b0), .TO_W(16), .TIMEOUT(8)
    ) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    typedef struct {
        int          d;          // 0 = dut_a, 1 = dut_b
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          rdy_at;     // cycle (T-index) with mem_ready=1, 0 = never
        logic [31:0] rdata;
        logic        drop_sel;   // release PSEL/PENABLE from T2 on
        int          exp_vcyc;   // cycles with mem_valid high
        int          exp_pr;     // T-index of the PREADY cycle
        logic        exp_err;
        logic [31:0] exp_prdata;
        logic [3:0]  exp_wstrb;
        int          gap;        // expected cycles since previous PREADY, 0 = skip
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic sel, input logic en, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic rdy, input logic [31:0] rdata);
        ifa.io_apbOut_PSEL    = (d == 0) ? sel   : 1'b0;
        ifa.io_apbOut_PENABLE = (d == 0) ? en    : 1'b0;
        ifa.io_apbOut_PWRITE  = (d == 0) ? wr    : 1'b0;
        ifa.io_apbOut_PADDR   = (d == 0) ? addr  : 32'h0;
        ifa.io_apbOut_PWDATA  = (d == 0) ? wdata : 32'h0;
        ifa.io_apbOut_PSTRB   = (d == 0) ? strb  : 4'h0;
        ifa.mem_ready         = (d == 0) ? rdy   : 1'b0;
        ifa.mem_rdata         = (d == 0) ? rdata : 32'h0;
        ifb.io_apbOut_PSEL    = (d == 1) ? sel   : 1'b0;
        ifb.io_apbOut_PENABLE = (d == 1) ? en    : 1'b0;
        ifb.io_apbOut_PWRITE  = (d == 1) ? wr    : 1'b0;
        ifb.io_apbOut_PADDR   = (d == 1) ? addr  : 32'h0;
        ifb.io_apbOut_PWDATA  = (d == 1) ? wdata : 32'h0;
        ifb.io_apbOut_PSTRB   = (d == 1) ? strb  : 4'h0;
        ifb.mem_ready         = (d == 1) ? rdy   : 1'b0;
        ifb.mem_rdata         = (d == 1) ? rdata : 32'h0;
    endtask

    task automatic sample(input int d, output logic mv, output logic [31:0] ma,
                          output logic [31:0] mw, output logic [3:0] ms,
                          output logic pr, output logic pe, output logic [31:0] prd);
        if (d == 0) begin
            mv = ifa.mem_valid; ma = ifa.mem_addr; mw = ifa.mem_wdata; ms = ifa.mem_wstrb;
            pr = ifa.io_apbOut_PREADY; pe = ifa.io_apbOut_PSLVERROR; prd = ifa.io_apbOut_PRDATA;
        end else begin
            mv = ifb.mem_valid; ma = ifb.mem_addr; mw = ifb.mem_wdata; ms = ifb.mem_wstrb;
            pr = ifb.io_apbOut_PREADY; pe = ifb.io_apbOut_PSLVERROR; prd = ifb.io_apbOut_PRDATA;
        end
    endtask

    function automatic vec_t mk(int d, logic wr, logic [31:0] addr, logic [31:0] wdata,
                                logic [3:0] strb, int rdy_at, logic [31:0] rdata,
                                logic drop_sel, int exp_vcyc, int exp_pr, logic exp_err,
                                logic [31:0] exp_prdata, logic [3:0] exp_wstrb, int gap);
        vec_t v;
        v.d = d; v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.rdy_at = rdy_at; v.rdata = rdata; v.drop_sel = drop_sel;
        v.exp_vcyc = exp_vcyc; v.exp_pr = exp_pr; v.exp_err = exp_err;
        v.exp_prdata = exp_prdata; v.exp_wstrb = exp_wstrb; v.gap = gap;
        return v;
    endfunction

    // One APB transfer starting with the setup phase in the next cycle (T0);
    // returns right after sampling the PREADY cycle so the next call is back-to-back.
    task automatic run_vec(input vec_t v, input int idx);
        logic mv, pr, pe, sel, stable;
        logic [31:0] ma, mw, prd, prdata_s;
        logic [3:0] ms;
        logic perr_s;
        int vcyc, prc;
        vcyc = 0; prc = -1; stable = 1'b1; perr_s = 1'b0; prdata_s = 32'h0;
        @(posedge clk); #1;
        drive(v.d, 1'b1, 1'b0, v.wr, v.addr, v.wdata, v.strb, 1'b0, v.rdata);
        @(negedge clk);
        sample(v.d, mv, ma, mw, ms, pr, pe, prd);
        chk($sformatf("v%0d_t0_quiet", idx), {62'h0, mv, pr}, 64'h0);
        for (int k = 1; k <= 40 && prc < 0; k++) begin
            @(posedge clk); #1;
            sel = (v.drop_sel && k >= 2) ? 1'b0 : 1'b1;
            drive(v.d, sel, sel, v.wr, v.addr, v.wdata, v.strb, (v.rdy_at == k), v.rdata);
            @(negedge clk);
            sample(v.d, mv, ma, mw, ms, pr, pe, prd);
            if (mv) begin
                vcyc++;
                if (ma !== v.addr || ms !== v.exp_wstrb || (v.wr && mw !== v.wdata))
                    stable = 1'b0;
            end
            if (pr) begin
                prc = k; perr_s = pe; prdata_s = prd;
                if (v.gap != 0)
                    chk($sformatf("v%0d_pready_gap", idx), 64'(cyc - last_pr), 64'(v.gap));
                last_pr = cyc;
            end
        end
        chk($sformatf("v%0d_valid_cycles", idx), 64'(vcyc), 64'(v.exp_vcyc));
        chk($sformatf("v%0d_pready_cycle", idx), 64'(prc), 64'(v.exp_pr));
        chk($sformatf("v%0d_pslverr", idx), {63'h0, perr_s}, {63'h0, v.exp_err});
        chk($sformatf("v%0d_prdata", idx), {32'h0, prdata_s}, {32'h0, v.exp_prdata});
        chk($sformatf("v%0d_req_fields", idx), {63'h0, stable}, 64'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic mv, pr, pe, bad;
        logic [31:0] ma, mw, prd;
        logic [3:0] ms;
        int npr;

        //        d  wr    addr          wdata         strb    rdy rdata         drop  vc pr err prdata        wstrb    gap
        vt[0]  = mk(0, 1'b0, 32'h0000_0100, 32'h0,        4'h0,   1, 32'hDEAD_BEEF, 1'b0, 1, 2, 1'b0, 32'hDEAD_BEEF, 4'b0000, 0);
        vt[1]  = mk(0, 1'b1, 32'h0000_0104, 32'h1122_3344, 4'b0110, 5, 32'hFFFF_FFFF, 1'b0, 5, 6, 1'b0, 32'h0,        4'b0110, 0);
        vt[2]  = mk(0, 1'b0, 32'h0000_0200, 32'h0,        4'h0,   0, 32'h1234_5678, 1'b0, 8, 9, 1'b1, 32'h0,        4'b0000, 0);
        vt[3]  = mk(0, 1'b0, 32'h0000_0204, 32'h0,        4'h0,   8, 32'hCAFE_F00D, 1'b0, 8, 9, 1'b0, 32'hCAFE_F00D, 4'b0000, 0);
        vt[4]  = mk(0, 1'b0, 32'h0000_0208, 32'h0,        4'h0,   3, 32'h0BAD_C0DE, 1'b1, 3, 4, 1'b0, 32'h0BAD_C0DE, 4'b0000, 0);
        vt[5]  = mk(1, 1'b0, 32'h0000_2000, 32'h0,        4'h0,   0, 32'h5555_5555, 1'b0, 0, 1, 1'b1, 32'h0,        4'b0000, 0);
        vt[6]  = mk(1, 1'b1, 32'h0000_1002, 32'hAAAA_0000, 4'hF,   0, 32'h5555_5555, 1'b0, 0, 1, 1'b1, 32'h0,        4'b1111, 0);
        vt[7]  = mk(1, 1'b0, 32'h0000_0FFC, 32'h0,        4'h0,   0, 32'h5555_5555, 1'b0, 0, 1, 1'b1, 32'h0,        4'b0000, 0);
        vt[8]  = mk(1, 1'b0, 32'h0000_1FFC, 32'h0,        4'h0,   1, 32'hA5A5_5A5A, 1'b0, 1, 2, 1'b0, 32'hA5A5_5A5A, 4'b0000, 0);
        vt[9]  = mk(1, 1'b1, 32'h0000_1000, 32'h0000_0001, 4'b0001, 1, 32'hFFFF_FFFF, 1'b0, 1, 2, 1'b0, 32'h0,        4'b1111, 0);
        vt[10] = mk(1, 1'b1, 32'h0000_1004, 32'h0000_0002, 4'b0001, 1, 32'hFFFF_FFFF, 1'b0, 1, 2, 1'b0, 32'h0,        4'b1111, 3);
        vt[11] = mk(1, 1'b1, 32'h0000_1008, 32'h0000_0003, 4'b0001, 1, 32'hFFFF_FFFF, 1'b0, 1, 2, 1'b0, 32'h0,        4'b1111, 3);
        vt[12] = mk(1, 1'b1, 32'h0000_100C, 32'h0000_0004, 4'b0001, 1, 32'hFFFF_FFFF, 1'b0, 1, 2, 1'b0, 32'h0,        4'b1111, 3);

        // Reset state of both instances
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sample(d, mv, ma, mw, ms, pr, pe, prd);
            chk($sformatf("rst%0d_ctrl", d), {61'h0, mv, pr, pe}, 64'h0);
            chk($sformatf("rst%0d_addr_wdata", d), {ma, mw}, 64'h0);
            chk($sformatf("rst%0d_wstrb_prdata", d), {28'h0, ms, prd}, 64'h0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(vt[i], i);

        // Access phase without a setup phase must not start a transfer
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            drive(0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 1'b1, 32'h0);
            @(negedge clk);
            sample(0, mv, ma, mw, ms, pr, pe, prd);
            if (k > 0 && (mv || pr)) bad = 1'b1;
        end
        chk("nosetup_ignored", {63'h0, bad}, 64'h0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);

        // Reset on the 3rd issue cycle abandons the transfer
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 32'h0);
        npr = 0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            drive(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 32'h0);
            if (k == 3) reset = 1'b1;
            @(negedge clk);
            sample(0, mv, ma, mw, ms, pr, pe, prd);
            if (mv) npr++;
        end
        chk("rst_mid_valid_before", 64'(npr), 64'd3);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        @(negedge clk);
        sample(0, mv, ma, mw, ms, pr, pe, prd);
        chk("rst_mid_valid_after", {62'h0, mv, pr}, 64'h0);
        npr = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            sample(0, mv, ma, mw, ms, pr, pe, prd);
            if (pr || mv) npr++;
        end
        chk("rst_mid_no_pready", 64'(npr), 64'd0);
        run_vec(vt[0], 99);

        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
